// File: rtl/sha256_mem_responder.sv
// Word memory on the SHA-256 core's memory port, with a host preload/readback port and a hash-complete pulse.
// Optional access counters (rd_count/wr_count) are enabled by defining SHA_MEM_ACCESS_CNT_EN.
module sha256_mem_responder #(
    parameter int          DEPTH    = 256,
    parameter logic [15:0] OUT_BASE = 16'h0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_active,
    input  logic [15:0] mem_addr,
    input  logic        mem_we,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic        host_we,
    input  logic [15:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        host_rvalid,
    output logic        hash_ready,
    output logic        addr_err
`ifdef SHA_MEM_ACCESS_CNT_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    localparam logic [1:0] ST_HOST  = 2'd0;
    localparam logic [1:0] ST_CORE  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [31:0] mem [DEPTH];

    logic [1:0]  state_q, state_d;
    logic [31:0] mem_read_data_q, mem_read_data_d;
    logic [31:0] host_rdata_q, host_rdata_d;
    logic        host_rvalid_q, host_rvalid_d;
    logic        hash_ready_q, hash_ready_d;
    logic        addr_err_q, addr_err_d;
    logic [7:0]  mask_q, mask_d;
`ifdef SHA_MEM_ACCESS_CNT_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;
`endif

    logic          core_own;
    logic          host_acc;
    logic          core_in_range;
    logic          host_in_range;
    logic [15:0]   win_off;
    logic          core_in_win;
    logic [7:0]    mask_set;
    logic [AW-1:0] acc_idx;
    logic [31:0]   rd_word;
    logic          wr_en;
    logic [31:0]   wr_data;

    assign core_own      = (state_q != ST_HOST);
    assign host_ready    = (state_q == ST_HOST) && !core_active;
    assign host_acc      = host_valid && host_ready;
    assign core_in_range = ({1'b0, mem_addr} < DEPTH_L);
    assign host_in_range = ({1'b0, host_addr} < DEPTH_L);
    // Addresses below OUT_BASE wrap to large offsets and fall outside the window.
    assign win_off       = mem_addr - OUT_BASE;
    assign core_in_win   = (win_off < 16'd8);
    assign mask_set      = mask_q | (8'd1 << win_off[2:0]);
    // One shared array port: the owner of memory selects the address.
    assign acc_idx       = core_own ? mem_addr[AW-1:0] : host_addr[AW-1:0];
    assign rd_word       = mem[acc_idx];

    always_comb begin
        state_d         = state_q;
        mem_read_data_d = mem_read_data_q;
        host_rdata_d    = host_rdata_q;
        host_rvalid_d   = 1'b0;
        hash_ready_d    = 1'b0;
        addr_err_d      = addr_err_q;
        mask_d          = mask_q;
        wr_en           = 1'b0;
        wr_data         = host_wdata;
`ifdef SHA_MEM_ACCESS_CNT_EN
        rd_count_d      = rd_count_q;
        wr_count_d      = wr_count_q;
`endif
        case (state_q)
            ST_HOST: begin
                if (host_acc) begin
                    host_rvalid_d = !host_we;
                    if (host_in_range) begin
                        if (host_we) wr_en = 1'b1;
                        else         host_rdata_d = rd_word;
                    end else begin
                        addr_err_d = 1'b1;
                        if (!host_we) host_rdata_d = 32'h0;
                    end
                end
                if (core_active) begin
                    state_d = ST_CORE;
                    mask_d  = 8'h00;
`ifdef SHA_MEM_ACCESS_CNT_EN
                    rd_count_d = 16'h0;
                    wr_count_d = 16'h0;
`endif
                end
            end
            ST_CORE, ST_DRAIN: begin
                if (mem_we) begin
                    if (core_in_range) begin
                        wr_en   = 1'b1;
                        wr_data = mem_write_data;
`ifdef SHA_MEM_ACCESS_CNT_EN
                        if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
`endif
                    end else begin
                        addr_err_d = 1'b1;
                    end
                    if (core_in_win) begin
                        if (mask_set == 8'hFF) begin
                            hash_ready_d = 1'b1;
                            mask_d       = 8'h00;
                        end else begin
                            mask_d = mask_set;
                        end
                    end
                end else if (core_in_range) begin
                    mem_read_data_d = rd_word;
`ifdef SHA_MEM_ACCESS_CNT_EN
                    if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
`endif
                end else begin
                    mem_read_data_d = 32'h0;
                    addr_err_d      = 1'b1;
                end
                if (state_q == ST_DRAIN)  state_d = ST_HOST;
                else if (!core_active)    state_d = ST_DRAIN;
            end
            default: state_d = ST_HOST;
        endcase
        if (reset) wr_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_HOST;
            mem_read_data_q <= 32'h0;
            host_rdata_q    <= 32'h0;
            host_rvalid_q   <= 1'b0;
            hash_ready_q    <= 1'b0;
            addr_err_q      <= 1'b0;
            mask_q          <= 8'h00;
`ifdef SHA_MEM_ACCESS_CNT_EN
            rd_count_q      <= 16'h0;
            wr_count_q      <= 16'h0;
`endif
        end else begin
            state_q         <= state_d;
            mem_read_data_q <= mem_read_data_d;
            host_rdata_q    <= host_rdata_d;
            host_rvalid_q   <= host_rvalid_d;
            hash_ready_q    <= hash_ready_d;
            addr_err_q      <= addr_err_d;
            mask_q          <= mask_d;
`ifdef SHA_MEM_ACCESS_CNT_EN
            rd_count_q      <= rd_count_d;
            wr_count_q      <= wr_count_d;
`endif
        end
    end

    // Array is not reset; the read above samples old contents, so same-edge writes are read-first.
    always_ff @(posedge clk) begin
        if (wr_en) mem[acc_idx] <= wr_data;
    end

    assign mem_read_data = mem_read_data_q;
    assign host_rdata    = host_rdata_q;
    assign host_rvalid   = host_rvalid_q;
    assign hash_ready    = hash_ready_q;
    assign addr_err      = addr_err_q;
`ifdef SHA_MEM_ACCESS_CNT_EN
    assign rd_count      = rd_count_q;
    assign wr_count      = wr_count_q;
`endif

endmodule

// File: tb/tb_sha256_mem_responder.sv
// Bench for sha256_mem_responder: behavioural model with per-cycle compare, directed scenarios plus random traffic.
module tb_sha256_mem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_active;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        host_valid;
    logic        host_ready;
    logic        host_we;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_rvalid;
    logic        hash_ready;
    logic        addr_err;
`ifdef SHA_MEM_ACCESS_CNT_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    sha256_mem_responder #(.DEPTH(DEPTH), .OUT_BASE(16'h0100)) dut (
        .clk(clk), .reset(reset), .core_active(core_active),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data),
        .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .hash_ready(hash_ready), .addr_err(addr_err)
`ifdef SHA_MEM_ACCESS_CNT_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: ownership phase 0=host, 1=core, 2=drain
    int          phase;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] e_mrd, e_hrd;
    bit          e_hrv, e_hash, e_err;
    bit [7:0]    m_mask;
    int          m_rc, m_wc;
    bit          model_ok = 0;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            phase = 0; e_mrd = 0; e_hrd = 0; e_hrv = 0; e_hash = 0; e_err = 0;
            m_mask = 0; m_rc = 0; m_wc = 0; model_ok = 1;
        end else if (model_ok) begin
            e_hrv  = 0;
            e_hash = 0;
            if (phase == 0) begin
                if (host_valid && !core_active) begin
                    if (!host_we) e_hrv = 1;
                    if (int'(host_addr) < DEPTH) begin
                        if (host_we) m_mem[int'(host_addr)] = host_wdata;
                        else         e_hrd = m_mem[int'(host_addr)];
                    end else begin
                        e_err = 1;
                        if (!host_we) e_hrd = 0;
                    end
                end
                if (core_active) begin
                    phase = 1; m_mask = 0; m_rc = 0; m_wc = 0;
                end
            end else begin
                if (mem_we) begin
                    if (int'(mem_addr) < DEPTH) begin
                        m_mem[int'(mem_addr)] = mem_write_data;
                        if (m_wc < 65535) m_wc++;
                    end else e_err = 1;
                    if (mem_addr >= 16'h0100 && mem_addr <= 16'h0107) begin
                        m_mask[int'(mem_addr) - 256] = 1'b1;
                        if (m_mask == 8'hFF) begin
                            e_hash = 1;
                            m_mask = 0;
                        end
                    end
                end else if (int'(mem_addr) < DEPTH) begin
                    e_mrd = m_mem[int'(mem_addr)];
                    if (m_rc < 65535) m_rc++;
                end else begin
                    e_mrd = 0;
                    e_err = 1;
                end
                if (phase == 2)        phase = 0;
                else if (!core_active) phase = 2;
            end
        end
    end

    // Per-cycle compare on the falling edge
    always @(negedge clk) begin
        if (model_ok) begin
            chk("host_ready", {31'b0, host_ready}, {31'b0, (phase == 0) && !core_active});
            chk("host_rvalid", {31'b0, host_rvalid}, {31'b0, e_hrv});
            chk("host_rdata", host_rdata, e_hrd);
            chk("mem_read_data", mem_read_data, e_mrd);
            chk("hash_ready", {31'b0, hash_ready}, {31'b0, e_hash});
            chk("addr_err", {31'b0, addr_err}, {31'b0, e_err});
`ifdef SHA_MEM_ACCESS_CNT_EN
            chk("rd_count", {16'b0, rd_count}, 32'(m_rc));
            chk("wr_count", {16'b0, wr_count}, 32'(m_wc));
`endif
        end
    end

    int hash_pulses = 0;
    always @(negedge clk) if (hash_ready === 1'b1) hash_pulses++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        host_valid = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        mem_we = 0; mem_addr = 0; mem_write_data = 0;
    endtask

    logic [31:0] hwords [8];
    int          order [9];
    int          p0;

    initial begin
        hwords = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        order  = '{5, 2, 0, 7, 2, 1, 6, 3, 4};
        idle_inputs();
        core_active = 0;
        reset = 1;
        step(); step();
        reset = 0;
        chk("reset host_ready", {31'b0, host_ready}, 32'h1);
        chk("reset mem_read_data", mem_read_data, 32'h0);
        chk("reset addr_err", {31'b0, addr_err}, 32'h0);

        // Preload: back-to-back host writes; low 20 words get a known pattern
        for (int i = 0; i < DEPTH; i++) begin
            host_valid = 1; host_we = 1; host_addr = 16'(i);
            host_wdata = (i < 20) ? (32'hA5A50000 | 32'(i)) : $urandom;
            step();
        end
        host_we = 0; host_addr = 16'd5;
        step();
        host_valid = 0;
        chk("host rd5 rvalid", {31'b0, host_rvalid}, 32'h1);
        chk("host rd5 data", host_rdata, 32'hA5A50005);
        step();
        chk("host rvalid one pulse", {31'b0, host_rvalid}, 32'h0);

        // Out-of-range host read: zero data, sticky error
        host_valid = 1; host_we = 0; host_addr = 16'h0200;
        step();
        host_valid = 0;
        chk("oor rdata", host_rdata, 32'h0);
        chk("oor addr_err", {31'b0, addr_err}, 32'h1);
        repeat (5) step();
        chk("addr_err sticky", {31'b0, addr_err}, 32'h1);
        reset = 1; step(); reset = 0;
        chk("addr_err cleared", {31'b0, addr_err}, 32'h0);

        host_valid = 1; host_we = 1; host_addr = 16'd7; host_wdata = 32'h11111111;
        step();

        // Core phase: host request not accepted while core owns memory
        core_active = 1; host_addr = 16'd9; host_wdata = 32'hCAFEF00D;
        step();
        host_valid = 0;
        mem_addr = 16'd3; mem_we = 0;
        step();
        chk("core rd3", mem_read_data, 32'hA5A50003);
        mem_addr = 16'd7;
        step();
        mem_we = 1; mem_write_data = 32'hDEADBEEF;
        chk("rd7 old", mem_read_data, 32'h11111111);
        step();
        mem_we = 0;
        chk("rd7 holds on write", mem_read_data, 32'h11111111);
        step();
        chk("rd7 new", mem_read_data, 32'hDEADBEEF);

        // Hash window, out of order, 0x0102 twice
        p0 = hash_pulses;
        for (int k = 0; k < 9; k++) begin
            mem_we = 1; mem_addr = 16'h0100 + 16'(order[k]); mem_write_data = hwords[order[k]];
            step();
            if (k < 8) chk("no early hash", {31'b0, hash_ready}, 32'h0);
        end
        mem_we = 0; mem_addr = 16'd0;
        chk("hash pulse", {31'b0, hash_ready}, 32'h1);
        step();
        chk("hash one cycle", {31'b0, hash_ready}, 32'h0);
        chk("hash count", 32'(hash_pulses - p0), 32'd1);

        core_active = 0;
        step(); step();
        chk("back to host", {31'b0, host_ready}, 32'h1);
        host_valid = 1; host_we = 0; host_addr = 16'd9;
        step();
        host_valid = 0;
        chk("addr9 unwritten", host_rdata, 32'hA5A50009);

        // Reset mid-core with a read in flight
        core_active = 1; step(); step();
        for (int k = 0; k < 7; k++) begin
            mem_we = 1; mem_addr = 16'h0100 + 16'(k); mem_write_data = $urandom; step();
        end
        mem_we = 0; mem_addr = 16'd3; reset = 1; core_active = 0;
        step();
        reset = 0;
        chk("rst host_ready", {31'b0, host_ready}, 32'h1);
        chk("rst rvalid", {31'b0, host_rvalid}, 32'h0);
        chk("rst hash", {31'b0, hash_ready}, 32'h0);
        chk("rst mrd", mem_read_data, 32'h0);
`ifdef SHA_MEM_ACCESS_CNT_EN
        chk("rst rd_count", {16'b0, rd_count}, 32'h0);
        chk("rst wr_count", {16'b0, wr_count}, 32'h0);
`endif

        // Random traffic checked by the model
        for (int r = 0; r < 40; r++) begin
            int hc, cc;
            hc = $urandom_range(4, 20);
            for (int c = 0; c < hc; c++) begin
                host_valid = $urandom_range(0, 3) != 0;
                host_we    = $urandom_range(0, 1);
                host_addr  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(256, 600))
                                                         : 16'($urandom_range(0, 255));
                host_wdata = $urandom;
                if (r % 13 == 5 && c == 2) reset = 1;
                step();
                reset = 0;
            end
            core_active = 1;
            cc = $urandom_range(10, 40);
            for (int c = 0; c < cc; c++) begin
                int sel;
                host_valid = $urandom_range(0, 1);
                sel = $urandom_range(0, 9);
                mem_we = $urandom_range(0, 1);
                mem_addr = (sel < 4) ? 16'h0100 + 16'($urandom_range(0, 7)) :
                           (sel == 4) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 255));
                mem_write_data = $urandom;
                if (c == cc - 2) core_active = 0;
                step();
            end
            idle_inputs();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
